text_console: RTL and testbench
===============================

# text_console

Character-buffer writer feeding the VGA glyph renderer. Accepts ASCII bytes over a valid/ready stream, stores them in a COLS×ROWS character RAM at a hardware cursor, and handles newline, carriage return, backspace and line wrap. On the display side it converts the pixel scan position into the cell's character code and cell origin, the `char`/`initialX`/`initialY` inputs the sprite renderer consumes.

## Interface
Parameters:
- COLS, 20, characters per row.
- ROWS, 15, character rows.
- CHAR_W, 32, glyph width in pixels; power of two.
- CHAR_H, 32, glyph height in pixels; power of two.

Ports:
- clk  in  1  single system clock, shared with the renderer.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  write-stream byte valid.
- in_char  in  8  ASCII byte.
- in_ready  out  1  console can accept a byte this cycle.
- clear  in  1  single-cycle request to blank the screen and home the cursor.
- currentX  in  10  display scan X.
- currentY  in  10  display scan Y.
- char  out  8  character code at the scan cell, registered.
- initialX  out  10  cell origin X, registered.
- initialY  out  10  cell origin Y, registered.
- cursor_col  out  $clog2(COLS)  current cursor column.
- cursor_row  out  $clog2(ROWS)  current cursor row.
- busy  out  1  high in CLEAR or CLRROW.

## Operation
- Buffer: COLS×ROWS × 8-bit, dual-port.
  - The write side is owned by the FSM.
  - The read side is a synchronous read owned by the display path.
  - Address = row*COLS + col.
- The FSM has three states: IDLE, CLEAR and CLRROW.
- IDLE:
  - in_ready = !clear.
  - Transfer occurs when in_valid && in_ready.
  - Each transfer is processed in that same cycle, so IDLE sustains one byte per cycle.
- Byte handling:
  - 0x20–0x7E: write the byte at the cursor, then advance the cursor.
  - 0x0A (LF): col←0, row advances.
  - 0x0D (CR): col←0.
  - 0x08 (BS): if col>0, col←col−1 and write 0x20 at the new col. If col=0, no action.
  - All other codes are consumed and ignored.
- Advance: if col<COLS−1, col increments. Otherwise col←0 and row advances.
- Row advance:
  - If row<ROWS−1, row increments.
  - Otherwise row←0 and the FSM enters CLRROW.
- CLRROW:
  - Writes 0x20 to row 0, cols 0..COLS−1, one cell per cycle.
  - Returns to IDLE after COLS cycles.
  - in_ready=0 throughout.
- CLEAR:
  - Entered from IDLE when clear=1. clear beats a simultaneous in_valid; that byte is not accepted.
  - Also entered on reset.
  - Writes 0x20 to all COLS×ROWS cells, one per cycle.
  - Cursor ← (0,0) on entry.
  - Returns to IDLE after COLS×ROWS cycles.
- clear is ignored while in CLEAR or CLRROW.
- Display path:
  - col_r = currentX / CHAR_W and row_r = currentY / CHAR_H, implemented as shifts.
  - If col_r<COLS and row_r<ROWS: char←buffer[row_r*COLS+col_r], initialX←col_r*CHAR_W, initialY←row_r*CHAR_H.
  - Otherwise: char←0x20, initialX←0, initialY←0.
  - The display path runs in every state, including CLEAR and CLRROW.
- Reset values, applied asynchronously:
  - State = CLEAR with fill index 0.
  - in_ready=0, busy=1.
  - cursor=(0,0).
  - char=0x20, initialX=0, initialY=0.
  - Buffer contents are undefined until the fill completes.

## Timing
- Write latency: a byte accepted at edge N is written to RAM and the cursor is updated at edge N.
  - Read-during-write to the same address returns old data.
  - A display read issued at edge N+1 or later returns the new byte.
- Display latency: char/initialX/initialY are valid 1 cycle after currentX/currentY, all three aligned.
- Fill after reset: rst_n deasserts, then COLS×ROWS rising edges, then in_ready=1 on the next cycle (300 cycles at default parameters).
- CLRROW: the byte causing the wrap is accepted at edge N.
  - in_ready=0 from N+1 through N+COLS.
  - in_ready=1 at N+COLS+1.
- CLEAR from clear: clear=1 sampled at edge N, in_ready=0 from N+1, busy=1 for exactly COLS×ROWS cycles.
- rst_n asserted mid-CLRROW or mid-stream aborts immediately and restarts the full CLEAR.

## Test plan
- Reset fill:
  - Release rst_n and wait 300 cycles.
  - Required: in_ready=1, busy=0.
  - Scan all cells; every char=0x20.
- Single write and read-out:
  - Send 0x41 at reset cursor.
  - Required: cursor=(1,0).
  - Drive currentX=5, currentY=7; next cycle char=0x41, initialX=0, initialY=0.
  - currentX=37 → char=0x20, initialX=32.
- Column wrap:
  - Send 20 × 0x42.
  - Required: cursor=(0,1).
  - Cell (19,0) reads 0x42 at initialX=608, initialY=0.
- Control codes:
  - Send "AB", then 0x08.
  - Required: cursor=(1,0), cell(1,0)=0x20, cell(0,0)=0x41.
  - Send 0x0A → cursor=(0,1). Send 0x0D at col 3 → col=0.
  - Send 0x07 → consumed, no cursor change.
- Row wrap:
  - Fill to cursor=(0,14), then send 0x0A.
  - Required: in_ready=0 for exactly 20 cycles, cursor=(0,0).
  - Row 0 reads all 0x20; row 1 contents unchanged.
- Clear priority and out-of-range:
  - Assert clear and in_valid with 0x43 in the same cycle.
  - Required: byte not written, busy=1 for 300 cycles, cursor=(0,0).
  - currentX=700 → char=0x20, initialX=0, initialY=0.

Source files
------------

// File: rtl/text_console.sv
// Character-buffer console: takes an ASCII byte stream into a COLS x ROWS text RAM
// at a hardware cursor, and serves the scan-position cell to the glyph renderer.
module text_console #(
  parameter int COLS   = 20,
  parameter int ROWS   = 15,
  parameter int CHAR_W = 32,
  parameter int CHAR_H = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [7:0]                in_char,
  output logic                      in_ready,
  input  logic                      clear,
  input  logic [9:0]                currentX,
  input  logic [9:0]                currentY,
  output logic [7:0]                char,
  output logic [9:0]                initialX,
  output logic [9:0]                initialY,
  output logic [$clog2(COLS)-1:0]   cursor_col,
  output logic [$clog2(ROWS)-1:0]   cursor_row,
  output logic                      busy
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int CELLS = COLS * ROWS;
  localparam int AW    = $clog2(CELLS);
  localparam int XSH   = $clog2(CHAR_W);
  localparam int YSH   = $clog2(CHAR_H);

  typedef enum logic [1:0] {IDLE, CLEAR, CLRROW} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   fill_idx, fill_next;
  logic [CW-1:0]   col_next;
  logic [RW-1:0]   row_next;
  logic            adv_row;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [7:0]      mem_wdata;
  logic [AW-1:0]   cur_addr;

  logic [7:0]      mem [CELLS];

  logic [9:0]      col_r, row_r;
  logic            in_range;
  logic [AW-1:0]   rd_addr;

  assign cur_addr = AW'(cursor_row) * AW'(COLS) + AW'(cursor_col);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      fill_idx   <= '0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      state      <= state_next;
      fill_idx   <= fill_next;
      cursor_col <= col_next;
      cursor_row <= row_next;
    end
  end

  // Bytes are fully handled in the cycle they are accepted; fills sweep one cell per cycle.
  always_comb begin
    state_next = state;
    fill_next  = fill_idx;
    col_next   = cursor_col;
    row_next   = cursor_row;
    adv_row    = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = cur_addr;
    mem_wdata  = 8'h20;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !clear;
        if (clear) begin
          state_next = CLEAR;
          fill_next  = '0;
          col_next   = '0;
          row_next   = '0;
        end else if (in_valid) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            mem_we    = 1'b1;
            mem_wdata = in_char;
            if (cursor_col < CW'(COLS - 1)) begin
              col_next = cursor_col + CW'(1);
            end else begin
              col_next = '0;
              adv_row  = 1'b1;
            end
          end else if (in_char == 8'h0A) begin
            col_next = '0;
            adv_row  = 1'b1;
          end else if (in_char == 8'h0D) begin
            col_next = '0;
          end else if (in_char == 8'h08 && cursor_col != '0) begin
            col_next  = cursor_col - CW'(1);
            mem_we    = 1'b1;
            mem_waddr = cur_addr - AW'(1);
          end
          // Wrapping off the last row scrolls nothing; row 0 is simply blanked for reuse.
          if (adv_row) begin
            if (cursor_row < RW'(ROWS - 1)) begin
              row_next = cursor_row + RW'(1);
            end else begin
              row_next   = '0;
              state_next = CLRROW;
              fill_next  = '0;
            end
          end
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = fill_idx;
        if (fill_idx == AW'(CELLS - 1)) state_next = IDLE;
        else                             fill_next  = fill_idx + AW'(1);
      end
      CLRROW: begin
        mem_we    = 1'b1;
        mem_waddr = fill_idx;
        if (fill_idx == AW'(COLS - 1)) state_next = IDLE;
        else                            fill_next  = fill_idx + AW'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign col_r    = currentX >> XSH;
  assign row_r    = currentY >> YSH;
  assign in_range = (col_r < 10'(COLS)) && (row_r < 10'(ROWS));
  assign rd_addr  = AW'(row_r) * AW'(COLS) + AW'(col_r);

  // Synchronous read; a same-edge write is not visible until the following read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char     <= 8'h20;
      initialX <= '0;
      initialY <= '0;
    end else if (in_range) begin
      char     <= mem[rd_addr];
      initialX <= currentX & ~10'(CHAR_W - 1);
      initialY <= currentY & ~10'(CHAR_H - 1);
    end else begin
      char     <= 8'h20;
      initialX <= '0;
      initialY <= '0;
    end
  end

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: reset fill, a table of write/read vectors,
// then column wrap, row wrap, clear priority and mid-stream reset sequences.
module tb_text_console;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_char = 8'h00;
  logic       in_ready;
  logic       clear = 1'b0;
  logic [9:0] currentX = 10'd0;
  logic [9:0] currentY = 10'd0;
  logic [7:0] char;
  logic [9:0] initialX, initialY;
  logic [4:0] cursor_col;
  logic [3:0] cursor_row;
  logic       busy;

  int vec_count  = 0;
  int fail_count = 0;

  text_console dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .clear      (clear),
    .currentX   (currentX),
    .currentY   (currentY),
    .char       (char),
    .initialX   (initialX),
    .initialY   (initialY),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         send;
    logic [7:0] b;
    logic [9:0] x, y;
    logic [7:0] ch;
    logic [9:0] ix, iy;
    logic [4:0] col;
    logic [3:0] row;
  } vec_t;

  vec_t vecs[16];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] c);
    int w = 0;
    while (!in_ready && w < 1000) begin
      tick();
      w++;
    end
    if (!in_ready) checkOutput("ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_char  = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic readCell(input int x, input int y);
    currentX = 10'(x);
    currentY = 10'(y);
    tick();
  endtask

  task automatic checkCell(input string name, input int x, input int y,
                           input logic [7:0] ch, input logic [9:0] ix, input logic [9:0] iy);
    readCell(x, y);
    checkOutput({name, "_char"}, {24'd0, char}, {24'd0, ch});
    checkOutput({name, "_ix"}, {22'd0, initialX}, {22'd0, ix});
    checkOutput({name, "_iy"}, {22'd0, initialY}, {22'd0, iy});
  endtask

  task automatic checkCursor(input string name, input logic [4:0] col, input logic [3:0] row);
    checkOutput({name, "_col"}, {27'd0, cursor_col}, {27'd0, col});
    checkOutput({name, "_row"}, {28'd0, cursor_row}, {28'd0, row});
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;

    vecs[0]  = '{1'b1, 8'h41, 10'd5,    10'd7,    8'h41, 10'd0,   10'd0,   5'd1, 4'd0};
    vecs[1]  = '{1'b0, 8'h00, 10'd37,   10'd7,    8'h20, 10'd32,  10'd0,   5'd1, 4'd0};
    vecs[2]  = '{1'b1, 8'h42, 10'd37,   10'd0,    8'h42, 10'd32,  10'd0,   5'd2, 4'd0};
    vecs[3]  = '{1'b1, 8'h08, 10'd32,   10'd0,    8'h20, 10'd32,  10'd0,   5'd1, 4'd0};
    vecs[4]  = '{1'b0, 8'h00, 10'd0,    10'd0,    8'h41, 10'd0,   10'd0,   5'd1, 4'd0};
    vecs[5]  = '{1'b1, 8'h07, 10'd0,    10'd0,    8'h41, 10'd0,   10'd0,   5'd1, 4'd0};
    vecs[6]  = '{1'b1, 8'h0A, 10'd0,    10'd32,   8'h20, 10'd0,   10'd32,  5'd0, 4'd1};
    vecs[7]  = '{1'b1, 8'h43, 10'd31,   10'd63,   8'h43, 10'd0,   10'd32,  5'd1, 4'd1};
    vecs[8]  = '{1'b1, 8'h44, 10'd32,   10'd32,   8'h44, 10'd32,  10'd32,  5'd2, 4'd1};
    vecs[9]  = '{1'b1, 8'h45, 10'd64,   10'd32,   8'h45, 10'd64,  10'd32,  5'd3, 4'd1};
    vecs[10] = '{1'b1, 8'h0D, 10'd0,    10'd32,   8'h43, 10'd0,   10'd32,  5'd0, 4'd1};
    vecs[11] = '{1'b1, 8'h08, 10'd0,    10'd32,   8'h43, 10'd0,   10'd32,  5'd0, 4'd1};
    vecs[12] = '{1'b1, 8'h00, 10'd639,  10'd479,  8'h20, 10'd608, 10'd448, 5'd0, 4'd1};
    vecs[13] = '{1'b1, 8'h7F, 10'd640,  10'd0,    8'h20, 10'd0,   10'd0,   5'd0, 4'd1};
    vecs[14] = '{1'b0, 8'h00, 10'd0,    10'd480,  8'h20, 10'd0,   10'd0,   5'd0, 4'd1};
    vecs[15] = '{1'b0, 8'h00, 10'd1023, 10'd1023, 8'h20, 10'd0,   10'd0,   5'd0, 4'd1};

    // Reset state, with a scan position that would otherwise produce nonzero outputs
    currentX = 10'd100;
    currentY = 10'd100;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd1);
    checkOutput("rst_char", {24'd0, char}, 32'h20);
    checkOutput("rst_ix", {22'd0, initialX}, 32'd0);
    checkOutput("rst_iy", {22'd0, initialY}, 32'd0);
    checkCursor("rst_cursor", 5'd0, 4'd0);

    // Fill takes exactly 300 edges after release
    rst_n = 1'b1;
    repeat (299) tick();
    checkOutput("fill_299_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("fill_299_busy", {31'd0, busy}, 32'd1);
    tick();
    checkOutput("fill_300_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("fill_300_busy", {31'd0, busy}, 32'd0);

    for (int r = 0; r < 15; r++) begin
      for (int c = 0; c < 20; c++) begin
        readCell(c * 32, r * 32);
        checkOutput($sformatf("fill_cell_%0d_%0d", c, r), {24'd0, char}, 32'h20);
      end
    end

    for (int i = 0; i < 16; i++) begin
      if (vecs[i].send) applyStimulus(vecs[i].b);
      readCell(int'(vecs[i].x), int'(vecs[i].y));
      checkOutput($sformatf("vec%0d_char", i), {24'd0, char}, {24'd0, vecs[i].ch});
      checkOutput($sformatf("vec%0d_ix", i), {22'd0, initialX}, {22'd0, vecs[i].ix});
      checkOutput($sformatf("vec%0d_iy", i), {22'd0, initialY}, {22'd0, vecs[i].iy});
      checkCursor($sformatf("vec%0d_cursor", i), vecs[i].col, vecs[i].row);
    end

    // Column wrap on row 2
    applyStimulus(8'h0A);
    repeat (20) applyStimulus(8'h42);
    checkCursor("colwrap_cursor", 5'd0, 4'd3);
    checkCell("colwrap_last", 608, 64, 8'h42, 10'd608, 10'd64);
    checkCell("colwrap_first", 0, 64, 8'h42, 10'd0, 10'd64);

    // Row wrap from the last row
    repeat (11) applyStimulus(8'h0A);
    checkCursor("pre_rowwrap_cursor", 5'd0, 4'd14);
    applyStimulus(8'h0A);
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      cnt++;
      tick();
    end
    checkOutput("clrrow_ready_low_cycles", cnt, 32'd20);
    checkCursor("rowwrap_cursor", 5'd0, 4'd0);
    for (int c = 0; c < 20; c++) begin
      readCell(c * 32, 0);
      checkOutput($sformatf("rowwrap_row0_%0d", c), {24'd0, char}, 32'h20);
    end
    checkCell("rowwrap_row1_c0", 0, 32, 8'h43, 10'd0, 10'd32);
    checkCell("rowwrap_row1_c1", 32, 32, 8'h44, 10'd32, 10'd32);
    checkCell("rowwrap_row1_c2", 64, 32, 8'h45, 10'd64, 10'd32);

    // Clear beats a simultaneous byte
    currentX = 10'd0;
    currentY = 10'd0;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_char  = 8'h43;
    #1;
    checkOutput("clear_blocks_ready", {31'd0, in_ready}, 32'd0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    checkOutput("clear_busy_start", {31'd0, busy}, 32'd1);
    cnt = busy ? 1 : 0;
    tick();
    checkOutput("clear_byte_not_written", {24'd0, char}, 32'h20);
    while (busy && cnt < 1000) begin
      cnt++;
      tick();
    end
    checkOutput("clear_busy_cycles", cnt, 32'd300);
    checkOutput("clear_done_ready", {31'd0, in_ready}, 32'd1);
    checkCursor("clear_cursor", 5'd0, 4'd0);
    checkCell("clear_out_of_range", 700, 0, 8'h20, 10'd0, 10'd0);
    checkCell("clear_row1_blank", 0, 32, 8'h20, 10'd0, 10'd32);

    // Asynchronous reset in the middle of the stream
    applyStimulus(8'h5A);
    checkCell("pre_reset_cell", 32, 0, 8'h20, 10'd32, 10'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_char", {24'd0, char}, 32'h20);
    checkOutput("async_rst_ix", {22'd0, initialX}, 32'd0);
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd1);
    checkOutput("async_rst_ready", {31'd0, in_ready}, 32'd0);
    checkCursor("async_rst_cursor", 5'd0, 4'd0);
    tick();
    rst_n = 1'b1;
    repeat (300) tick();
    checkOutput("refill_ready", {31'd0, in_ready}, 32'd1);
    checkCell("refill_cell0", 0, 0, 8'h20, 10'd0, 10'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule
